instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Program sequencer directly upstream of the simple processor top. It holds a small loadable program store and drives the processor's `DIN` and `Run` inputs one instruction at a time. It supplies the immediate word for two-word `mvi` instructions and waits for the processor's `Done` before advancing. It replaces hand-timed `DIN` stimulus with a self-paced instruction stream.

## Interface
- `DEPTH`, 32: program store depth in 9-bit words.
- `AW`, 5: address width, equal to clog2(DEPTH).
- `WDOG_CYCLES`, 16: watchdog limit in cycles; used only when `FETCH_WDOG_EN` is defined.
- `Clock`  in  1  single clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle pulse that begins execution at address 0.
- `Last_addr`  in  AW  address of the last instruction word; sampled on the accepted `Start`.
- `Prog_we`  in  1  program store write enable.
- `Prog_addr`  in  AW  program store write address.
- `Prog_data`  in  9  program store write data.
- `Done`  in  1  instruction-complete strobe from the processor.
- `DIN`  out  9  registered instruction or immediate word to the processor.
- `Run`  out  1  registered; high for exactly one cycle per instruction issue.
- `PC`  out  AW  address of the instruction currently executing.
- `Busy`  out  1  high in ISSUE, IMM and WAIT.
- `Halted`  out  1  high in HALT.
- `Error`  out  1  watchdog expiry flag; sticky until the next accepted `Start` or reset.

## Operation
- Instruction format: IIIXXXYYY, with the opcode in bits [8:6]. `OP_MVI` = 3'b001 is the only two-word instruction.
- States and transitions:
  - IDLE: `Run`=0 and `DIN`=0. An accepted `Start` sets PC=0, latches `Last_addr`, and moves to ISSUE.
  - ISSUE: `DIN`=mem[PC], `Run`=1 for one cycle. Next state is IMM if the opcode is `OP_MVI`, otherwise WAIT.
  - IMM: `DIN`=mem[(PC+1) mod DEPTH], `Run`=0. If `Done` is high, advance; otherwise go to WAIT.
  - WAIT: `DIN` holds its value, `Run`=0. Advance when `Done` is high.
  - HALT: `Run`=0, `DIN` holds. An accepted `Start` restarts at ISSUE with PC=0.
- Advance rule:
  - Next PC = PC+1 for a single-word instruction, PC+2 for `mvi`, both mod DEPTH.
  - If the finished instruction's first word is at the latched Last_addr, go to HALT; otherwise go to ISSUE with the new PC.
- `Done` is sampled only in IMM and WAIT. `Done` in IDLE, ISSUE or HALT is ignored.
- `Start` is accepted only in IDLE or HALT, and only when `Prog_we`=0. If both are high, the write wins and `Start` is dropped.
- `Prog_we` writes only in IDLE or HALT; writes in any busy state are ignored. The store is a register array with no reset; its contents survive `Resetn`.
- Wrap-around: an `mvi` at DEPTH-1 takes its immediate from address 0.
- An `mvi` located at Last_addr still fetches its immediate at Last_addr+1 before halting.

## Timing
- Reset (asynchronous, any state, including mid-instruction): state=IDLE, `DIN`=0, `Run`=0, `PC`=0, `Busy`=0, `Halted`=0, `Error`=0.
- From an accepted `Start`, `Run` rises one cycle later, together with the first `DIN` word.
- `mvi` with `Done` in IMM: the immediate word is on `DIN` the cycle after `Run`, and the next `Run` follows the cycle after `Done`. Minimum issue interval is 2 cycles.
- Single-word instructions, with `Done` the cycle after `Run`: minimum issue interval is 2 cycles.
- All outputs are registered; there is no combinational path from `Done` to `DIN` or `Run`.

## Configuration
- `FETCH_WDOG_EN` defined:
  - A counter clears on entry to IMM or WAIT.
  - If `Done` is not seen within `WDOG_CYCLES` cycles, the block goes to HALT and sets `Error`=1.
- `FETCH_WDOG_EN` undefined: the block waits indefinitely for `Done`; `Error` is tied to 0 and there is no counter logic.

## Structure
- Shared package `simple_proc_pkg` holds:
  - the 9-bit word width constant;
  - opcode constants (`OP_MV`=3'b000, `OP_MVI`=3'b001, `OP_ADD`=3'b010, `OP_SUB`=3'b011);
  - the fetch state enum (IDLE, ISSUE, IMM, WAIT, HALT).
- One sub-module, `prog_store`: write port plus combinational read port, DEPTH x 9. The FSM, PC and watchdog remain in the top module.

## Test plan
- Reset and load: load mem[0]=9'b001_000_000, mem[1]=9'b111_001_111, mem[2]=9'b000_001_000, Last_addr=2, then Start. Required:
  - `Run` pulses with DIN=9'b001_000_000;
  - next cycle DIN=9'b111_001_111;
  - after `Done`, `Run` pulses with DIN=9'b000_001_000;
  - after its `Done`, `Halted`=1 and `PC`=2.
- `Done` delayed 5 cycles after a single-word issue: `DIN` holds, `Run` stays 0, and the next issue occurs exactly 1 cycle after `Done`.
- Wrap-around: `mvi` at address 31 with Last_addr=31. Required: immediate taken from mem[0], then HALT.
- Busy-time guards:
  - Start during WAIT is ignored (`PC` unchanged);
  - Prog_we during WAIT leaves mem unchanged on readback after HALT;
  - Start and Prog_we in the same cycle in IDLE: the write occurs and Busy stays 0.
- Reset mid-operation: deassert `Resetn` during IMM. Required: all outputs are 0 immediately, without waiting for a clock edge. After release, Start runs the program again from PC=0.
- With `FETCH_WDOG_EN` defined and `Done` never asserted: `Halted`=1 and `Error`=1 after 16 cycles in WAIT; the next Start clears `Error`.

Source files
------------

// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor and its instruction fetch unit:
// data word width, opcode encodings and the fetch sequencer state encoding.
package simple_proc_pkg;

  localparam int WORD_W = 9;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_MV  = 3'b000;
  localparam opcode_t OP_MVI = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_IMM,
    ST_WAIT,
    ST_HALT
  } fetch_state_e;

  // mvi is the only instruction followed by an immediate word.
  function automatic logic is_mvi(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3] == OP_MVI;
  endfunction

endpackage

// File: rtl/prog_store.sv
// Program store: DEPTH x 9-bit register array with one synchronous write port
// and one combinational read port.
module prog_store
  import simple_proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port.
  // NOTE: the array has no reset, so a loaded program survives Resetn and the
  // store can map onto plain storage cells without a reset network.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequences a loaded program into the processor one
// instruction at a time, supplying mvi immediates and pacing on Done.
// Optional watchdog: define FETCH_WDOG_EN to halt with Error when Done does
// not arrive within WDOG_CYCLES cycles.
module instr_fetch_unit
  import simple_proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
`ifdef FETCH_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 16
`endif
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [AW-1:0]     Last_addr,
  input  logic              Prog_we,
  input  logic [AW-1:0]     Prog_addr,
  input  logic [WORD_W-1:0] Prog_data,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic [AW-1:0]     PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  fetch_state_e      state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     last_q, last_d;
  logic              mvi_q, mvi_d;
  logic              run_q, run_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic [AW-1:0]     rd_addr, next_pc;
  logic [WORD_W-1:0] rd_data;
  logic              idle_like, start_ok, store_we;

`ifdef FETCH_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic           wdog_expired;
  assign wdog_expired = (wdog_q == WDW'(WDOG_CYCLES - 1));
`endif

  // Program writes and Start are only honoured while not executing; a write
  // in the same cycle as Start wins and the Start is dropped.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign store_we  = idle_like && Prog_we;
  assign start_ok  = idle_like && Start && !Prog_we;
  assign next_pc   = mvi_q ? pc_q + AW'(2) : pc_q + AW'(1);

  prog_store #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_store (
    .clk    (Clock),
    .we_i   (store_we),
    .waddr_i(Prog_addr),
    .wdata_i(Prog_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // Read address: the word that will be on DIN after the next state change.
  always_comb begin
    case (state_q)
      ST_ISSUE: rd_addr = pc_q + AW'(1);
      ST_IMM,
      ST_WAIT:  rd_addr = next_pc;
      default:  rd_addr = '0;
    endcase
  end

  // Next-state logic; DIN/Run are computed for the next state so they leave
  // the block straight from flops.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    mvi_d   = mvi_q;
    din_d   = din_q;
    run_d   = 1'b0;
`ifdef FETCH_WDOG_EN
    wdog_d  = '0;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok) begin
          state_d = ST_ISSUE;
          pc_d    = '0;
          last_d  = Last_addr;
          din_d   = rd_data;
          run_d   = 1'b1;
`ifdef FETCH_WDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        mvi_d = is_mvi(din_q);
        if (is_mvi(din_q)) begin
          state_d = ST_IMM;
          din_d   = rd_data;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_IMM, ST_WAIT: begin
        if (Done) begin
          if (pc_q == last_q) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_ISSUE;
            pc_d    = next_pc;
            din_d   = rd_data;
            run_d   = 1'b1;
          end
        end
`ifdef FETCH_WDOG_EN
        else if (wdog_expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else if (state_q == ST_IMM) begin
          state_d = ST_WAIT;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
`else
        else if (state_q == ST_IMM) begin
          state_d = ST_WAIT;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      mvi_q   <= 1'b0;
      din_q   <= '0;
      run_q   <= 1'b0;
`ifdef FETCH_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      mvi_q   <= mvi_d;
      din_q   <= din_d;
      run_q   <= run_d;
`ifdef FETCH_WDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign DIN    = din_q;
  assign Run    = run_q;
  assign PC     = pc_q;
  assign Busy   = (state_q == ST_ISSUE) || (state_q == ST_IMM) || (state_q == ST_WAIT);
  assign Halted = (state_q == ST_HALT);
`ifdef FETCH_WDOG_EN
  assign Error  = err_q;
`else
  assign Error  = 1'b0;
`endif

endmodule
